// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns: one column per clock through a shared GF(2^8) column mixer.
// Optional macro MIX_COLUMNS_INV_EN adds an 'inv' port selecting the inverse coefficients.
module mix_columns_seq #(
    parameter int NCOL   = 4,
    parameter int BYTE_W = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
`ifdef MIX_COLUMNS_INV_EN
    input  logic                         inv,
`endif
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NCOL*NCOL*BYTE_W-1:0]  in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NCOL*NCOL*BYTE_W-1:0]  out_data,
    output logic                         busy
);

    localparam int STATE_W = NCOL * NCOL * BYTE_W;
    localparam int COL_W   = NCOL * BYTE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           col_q, col_d;
    logic [STATE_W-1:0]   wr_q, wr_d;
    logic [COL_W-1:0]     col_s;
    logic [COL_W-1:0]     mixed_s;
    logic                 accept_s;
`ifdef MIX_COLUMNS_INV_EN
    logic                 inv_q, inv_d;
`endif

    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [COL_W-1:0] fwd_mix(input logic [COL_W-1:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    // 9, 11, 13 and 14 are built from x2/x4/x8 partial products
    function automatic logic [COL_W-1:0] inv_mix(input logic [COL_W-1:0] a);
        logic [7:0] b [4];
        logic [7:0] m9 [4], m11 [4], m13 [4], m14 [4];
        logic [7:0] x2, x4, x8;
        {b[0], b[1], b[2], b[3]} = a;
        for (int i = 0; i < 4; i++) begin
            x2 = xtime(b[i]);
            x4 = xtime(x2);
            x8 = xtime(x4);
            m9[i]  = x8 ^ b[i];
            m11[i] = x8 ^ x2 ^ b[i];
            m13[i] = x8 ^ x4 ^ b[i];
            m14[i] = x8 ^ x4 ^ x2;
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction
`endif

    function automatic logic [COL_W-1:0] col_get(input logic [STATE_W-1:0] s, input logic [1:0] c);
        case (c)
            2'd0:    return {s[127:120], s[95:88], s[63:56], s[31:24]};
            2'd1:    return {s[119:112], s[87:80], s[55:48], s[23:16]};
            2'd2:    return {s[111:104], s[79:72], s[47:40], s[15:8]};
            2'd3:    return {s[103:96],  s[71:64], s[39:32], s[7:0]};
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [STATE_W-1:0] col_put(input logic [STATE_W-1:0] s, input logic [1:0] c,
                                                   input logic [COL_W-1:0] v);
        logic [STATE_W-1:0] r;
        r = s;
        case (c)
            2'd0:    {r[127:120], r[95:88], r[63:56], r[31:24]} = v;
            2'd1:    {r[119:112], r[87:80], r[55:48], r[23:16]} = v;
            2'd2:    {r[111:104], r[79:72], r[47:40], r[15:8]}  = v;
            2'd3:    {r[103:96],  r[71:64], r[39:32], r[7:0]}   = v;
            default: r = s;
        endcase
        return r;
    endfunction

    assign col_s     = col_get(wr_q, col_q);
    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept_s  = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign out_data  = wr_q;

    always_comb begin
        mixed_s = fwd_mix(col_s);
`ifdef MIX_COLUMNS_INV_EN
        if (inv_q) begin
            mixed_s = inv_mix(col_s);
        end else begin
            mixed_s = fwd_mix(col_s);
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        wr_d    = wr_q;
`ifdef MIX_COLUMNS_INV_EN
        inv_d   = inv_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_d = BUSY;
                    col_d   = 2'd0;
                    wr_d    = in_data;
`ifdef MIX_COLUMNS_INV_EN
                    inv_d   = inv;
`endif
                end else if ((state_q == DONE) && out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            BUSY: begin
                wr_d  = col_put(wr_q, col_q, mixed_s);
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
                col_d   = 2'd0;
            end
        endcase
    end

    // Reset discards any partially mixed state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            wr_q    <= {STATE_W{1'b0}};
`ifdef MIX_COLUMNS_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            wr_q    <= wr_d;
`ifdef MIX_COLUMNS_INV_EN
            inv_q   <= inv_d;
`endif
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Randomised and directed checks of mix_columns_seq against a GF(2^8) matrix reference model.
module tb_mix_columns_seq;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
`ifdef MIX_COLUMNS_INV_EN
    logic         inv;
`endif

    int checks = 0;
    int errors = 0;

    mix_columns_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
`ifdef MIX_COLUMNS_INV_EN
        .inv       (inv),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Circulant matrix product over every column of the row-major state.
    function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inverse);
        logic [7:0]   base [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (inverse) begin
            base[0] = 8'd14; base[1] = 8'd11; base[2] = 8'd13; base[3] = 8'd9;
        end else begin
            base[0] = 8'd2;  base[1] = 8'd3;  base[2] = 8'd1;  base[3] = 8'd1;
        end
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(base[(j - row + 4) % 4], s[127 - 8*(4*j + c) -: 8]);
                r[127 - 8*(4*row + c) -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mk_col0(input logic [31:0] b);
        logic [127:0] s;
        s = 128'h0;
        s[127:120] = b[31:24];
        s[95:88]   = b[23:16];
        s[63:56]   = b[15:8];
        s[31:24]   = b[7:0];
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Waits (bounded) for out_valid after an acceptance edge, checks latency and data.
    task automatic wait_result(input string tag, input logic [127:0] exp);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq({tag, "_lat"}, 128'(cyc), 128'(4));
        check_eq({tag, "_data"}, out_data, exp);
    endtask

    task automatic run_vec(input string tag, input logic [127:0] d, input logic [127:0] exp);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        check_eq({tag, "_rdy"}, 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = rnd128();
        check_eq({tag, "_busy"}, 128'(busy), 128'(1));
        wait_result(tag, exp);
        if (out_ready) begin
            @(posedge clk); #1;
            check_eq({tag, "_idle"}, 128'({out_valid, in_ready}), 128'(1));
        end
    endtask

    logic [127:0] d;
    logic [127:0] hold;
    logic [127:0] nxt;

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 128'h0;
        out_ready = 1'b1;
`ifdef MIX_COLUMNS_INV_EN
        inv       = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_busy",      128'(busy),      128'(0));
        check_eq("rst_out_data",  out_data,        128'h0);
        check_eq("rst_in_ready",  128'(in_ready),  128'(1));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("idle_out_valid", 128'(out_valid), 128'(0));
        check_eq("idle_in_ready",  128'(in_ready),  128'(1));

        run_vec("fips", 128'hd4e0b81e_bfb44127_5d521198_30aef1e5,
                128'h04e04828_66cbf806_8119d326_e59a7a4c);
        run_vec("col_db", mk_col0(32'hdb135345), mk_col0(32'h8e4da1bc));
        run_vec("col_f2", mk_col0(32'hf20a225c), mk_col0(32'h9fdc589d));
        run_vec("col_01", mk_col0(32'h01010101), mk_col0(32'h01010101));
        run_vec("col_2d", mk_col0(32'h2d26314c), mk_col0(32'h4d7ebdf8));

        for (int i = 0; i < 8; i++) begin
            d = rnd128();
            run_vec($sformatf("rnd%0d", i), d, ref_mix(d, 1'b0));
        end

        // Backpressure: DONE held, in_valid ignored, then same-edge re-accept.
        out_ready = 1'b0;
        d = rnd128();
        run_vec("bp", d, ref_mix(d, 1'b0));
        hold = out_data;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = rnd128();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_eq("bp_stable", out_data, hold);
            check_eq("bp_ctrl", 128'({out_valid, in_ready, busy}), 128'(3'b100));
        end
        check_eq("bp_hold_ref", hold, ref_mix(d, 1'b0));
        @(negedge clk);
        out_ready = 1'b1;
        nxt = rnd128();
        in_data = nxt;
        #1;
        check_eq("bp_rdy_comb", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("bp_busy_next", 128'({busy, out_valid}), 128'(2'b10));
        wait_result("bp_next", ref_mix(nxt, 1'b0));

        // Reset while BUSY at col=2 discards the work.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = rnd128();
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check_eq("mid_busy", 128'(busy), 128'(1));
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_ctrl", 128'({out_valid, busy, in_ready}), 128'(3'b001));
        check_eq("mid_rst_data", out_data, 128'h0);
        @(negedge clk);
        reset_n = 1'b1;
        d = rnd128();
        run_vec("post_rst", d, ref_mix(d, 1'b0));

`ifdef MIX_COLUMNS_INV_EN
        inv = 1'b1;
        run_vec("inv_fips", 128'h04e04828_66cbf806_8119d326_e59a7a4c,
                128'hd4e0b81e_bfb44127_5d521198_30aef1e5);
        for (int i = 0; i < 4; i++) begin
            d = rnd128();
            inv = 1'b0;
            run_vec("rt_fwd", d, ref_mix(d, 1'b0));
            hold = ref_mix(d, 1'b0);
            inv = 1'b1;
            run_vec("rt_inv", hold, d);
        end
        inv = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
